// File: rtl/rotate_step_sequencer_pkg.sv
// Shared defaults, FSM encoding and direction constants for the rotate step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rotate_step_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;
  localparam int DEF_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_step_sequencer_core.sv
// Combinational WIDTH-bit rotator: y = a rotated left/right by amt, no fill bits.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
module rotate_core
  import rotate_step_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] shr;
  logic [2*WIDTH-1:0] shl;

  // Shifting the word concatenated with itself turns the rotate into a plain shift.
  always_comb begin
    dbl = {a, a};
    shr = dbl >> amt;
    shl = dbl << amt;
    if (lr == DIR_RIGHT) begin
      y = shr[WIDTH-1:0];
    end else begin
      y = shl[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/rotate_step_sequencer.sv
// Accepts a rotate command and streams one rotated beat per step, tagging the final one last.
// Latency: first beat valid the cycle after accept; one idle cycle between commands.
// Backpressure: out_ready low holds every register; in_ready only while idle.
module rotate_step_sequencer
  import rotate_step_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_lr,
  input  logic [CNT_W-1:0] in_steps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic               lr_q, lr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic               vld_q, vld_d;

  logic [WIDTH-1:0]   rot_a;
  logic [AMT_W-1:0]   rot_amt;
  logic               rot_lr;
  logic [WIDTH-1:0]   rot_y;

  // One shared rotator: fed by the incoming command while idle, by its own output while emitting.
  always_comb begin
    if (state_q == IDLE) begin
      rot_a   = in_data;
      rot_amt = in_amt;
      rot_lr  = in_lr;
    end else begin
      rot_a   = data_q;
      rot_amt = amt_q;
      rot_lr  = lr_q;
    end
  end

  rotate_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_rotate_core (
    .a   (rot_a),
    .amt (rot_amt),
    .lr  (rot_lr),
    .y   (rot_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    amt_d   = amt_q;
    lr_d    = lr_q;
    data_d  = data_q;
    last_d  = last_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          amt_d   = in_amt;
          lr_d    = in_lr;
          data_d  = (in_steps == '0) ? in_data : rot_y;
          cnt_d   = (in_steps == '0) ? '0 : in_steps - CNT_W'(1);
          last_d  = (in_steps <= CNT_W'(1));
          vld_d   = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (vld_q && out_ready) begin
          if (last_q) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            data_d = rot_y;
            cnt_d  = cnt_q - CNT_W'(1);
            last_d = (cnt_q == CNT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      amt_q   <= '0;
      lr_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      amt_q   <= amt_d;
      lr_q    <= lr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_rotate_step_sequencer.sv
// Directed plus randomized bench for rotate_step_sequencer against a bit-index rotation model.
module tb_rotate_step_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_lr;
  logic [3:0] in_steps;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rotate_step_sequencer #(.WIDTH(8), .AMT_W(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_lr     (in_lr),
    .in_steps  (in_steps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result bit i takes source bit (i+s) for right, (i-s) for left, modulo 8.
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int s, input bit right);
    logic [7:0] r;
    int sh = s % 8;
    for (int i = 0; i < 8; i++) begin
      if (right) r[i] = d[(i + sh) % 8];
      else       r[i] = d[(i - sh + 8) % 8];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and drain every beat, optionally stalling at one beat and
  // poking a second command while stalled.
  task automatic run_cmd(input logic [7:0] d, input logic [2:0] a, input bit right,
                         input logic [3:0] n, input int stall_beat, input int stall_len,
                         input bit rnd_stall, input bit poke);
    int beats;
    int waited;
    logic [7:0] exp_d;
    beats = (n == 0) ? 1 : int'(n);
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("in_ready_before_cmd", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_amt = a; in_lr = right; in_steps = n;
    tick();
    in_valid = 1'b0; in_data = $urandom; in_amt = $urandom; in_steps = $urandom;
    for (int k = 1; k <= beats; k++) begin
      int stalls;
      exp_d = (n == 0) ? d : ref_rot(d, k * int'(a), right);
      stalls = (k == stall_beat) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < stalls; s++) begin
        out_ready = 1'b0;
        if (poke) begin
          in_valid = 1'b1; in_data = 8'hFF; in_steps = 4'd1;
        end
        #1;
        if (poke) check("in_ready_low_busy", in_ready, 0);
        tick();
        in_valid = 1'b0;
        check("stall_data_held", out_data, exp_d);
        check("stall_last_held", out_last, (k == beats));
        check("stall_valid_held", out_valid, 1);
      end
      out_ready = 1'b1;
      check("beat_valid", out_valid, 1);
      check("beat_data", out_data, exp_d);
      check("beat_last", out_last, (k == beats));
      check("beat_busy", busy, 1);
      tick();
    end
    check("end_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("end_busy", busy, 0);
    check("end_data_held", out_data, exp_d);
    out_ready = $urandom_range(0, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_lr = 1'b0;
    in_steps = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Constant expectations cross-check the model against hand-computed values.
    run_cmd(8'h81, 3'd1, 1'b0, 4'd3, 0, 0, 1'b0, 1'b0);
    check("tp1_beat3_const", out_data, 8'h0C);
    run_cmd(8'h01, 3'd3, 1'b1, 4'd2, 0, 0, 1'b0, 1'b0);
    check("tp2_beat2_const", out_data, 8'h04);
    run_cmd(8'hA5, 3'd5, 1'b1, 4'd0, 0, 0, 1'b0, 1'b0);
    check("tp3_pass_const", out_data, 8'hA5);
    run_cmd(8'h3C, 3'd0, 1'b0, 4'd4, 0, 0, 1'b0, 1'b0);
    run_cmd(8'h01, 3'd1, 1'b0, 4'd8, 0, 0, 1'b0, 1'b0);
    check("tp4_wrap_const", out_data, 8'h01);
    run_cmd(8'h5A, 3'd3, 1'b0, 4'd15, 0, 0, 1'b0, 1'b0);
    run_cmd(8'h81, 3'd2, 1'b1, 4'd3, 2, 5, 1'b0, 1'b1);
    check("tp5_beat3_const", out_data, 8'h06);

    // Asynchronous abort in the middle of beat 2.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_lr = 1'b0; in_steps = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort_pre_data", out_data, ref_rot(8'h81, 2, 1'b0));
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_last", out_last, 0);
    check("abort_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_beat", out_valid, 0);
    end
    run_cmd(8'h81, 3'd1, 1'b0, 4'd1, 0, 0, 1'b0, 1'b0);
    check("post_rst_cmd_const", out_data, 8'h03);

    for (int r = 0; r < 40; r++) begin
      run_cmd(8'($urandom), 3'($urandom), 1'($urandom), 4'($urandom),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
